// File: rtl/dram_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dram_burst_pkg
// Brief    : Shared state encoding and beat-geometry helpers for the DRAM
//            burst reader.
// Revision : 1.0  initial release
// ============================================================================
package dram_burst_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int beat_bytes(input int data_width);
      return data_width / 8;
   endfunction

   function automatic int beat_shift(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dram_burst_rob.sv
`default_nettype none
// ============================================================================
// Module   : dram_burst_rob
// Brief    : Reorder buffer: per-slot beat storage plus valid bits, with one
//            write port, one head read port and one clear port.
// Revision : 1.0  initial release
// ============================================================================
module dram_burst_rob
   import dram_burst_pkg::*;
#(
   parameter int dataWidth = 256,
   parameter int robDepth  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_wr_en,
   input  logic [$clog2(robDepth)-1:0] i_wr_slot,
   input  logic [dataWidth-1:0]        i_wr_data,
   input  logic                        i_clr_en,
   input  logic [$clog2(robDepth)-1:0] i_clr_slot,
   input  logic [$clog2(robDepth)-1:0] i_head_slot,
   output logic                        o_head_valid,
   output logic [dataWidth-1:0]        o_head_data,
   output logic [robDepth-1:0]         o_valid
);

   logic [dataWidth-1:0] r_mem [robDepth];
   logic [robDepth-1:0]  r_valid;

   // Data storage needs no reset; the valid bits alone gate visibility.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_slot] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
      end else begin
         if (i_wr_en) begin
            r_valid[i_wr_slot] <= 1'b1;
         end
         if (i_clr_en) begin
            r_valid[i_clr_slot] <= 1'b0;
         end
      end
   end

   assign o_head_valid = r_valid[i_head_slot];
   assign o_head_data  = r_mem[i_head_slot];
   assign o_valid      = r_valid;

endmodule
`default_nettype wire

// File: rtl/dram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : dram_burst_reader
// Brief    : Splits a burst read command into per-beat DRAM reads, reorders
//            the responses and streams them out in address order.
//            Optional macro DRAM_BURST_READER_STATS_EN adds beat/stall counters.
// Revision : 1.0  initial release
// ============================================================================
module dram_burst_reader
   import dram_burst_pkg::*;
#(
   parameter int addressWidth = 32,
   parameter int dataWidth    = 256,
   parameter int lenWidth     = 16,
   parameter int robDepth     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [addressWidth-1:0] cmd_payload_addr,
   input  logic [lenWidth-1:0]     cmd_payload_len,
   output logic                    dram_req_valid,
   input  logic                    dram_req_ready,
   output logic [addressWidth-1:0] dram_req_payload_addr,
   output logic [dataWidth-1:0]    dram_req_payload_data,
   output logic                    dram_req_payload_is_write,
   input  logic                    dram_resp_valid,
   output logic                    dram_resp_ready,
   input  logic [addressWidth-1:0] dram_resp_payload_addr,
   input  logic [dataWidth-1:0]    dram_resp_payload_data,
   input  logic                    dram_resp_payload_is_write,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [dataWidth-1:0]    out_payload_data,
   output logic                    out_payload_last,
   output logic                    busy,
   output logic                    err_unexpected
`ifdef DRAM_BURST_READER_STATS_EN
   ,
   output logic [31:0]             stat_beats,
   output logic [31:0]             stat_stall_cycles
`endif
);

   localparam int BEAT_BYTES = beat_bytes(dataWidth);
   localparam int SHIFT      = beat_shift(dataWidth);
   localparam int SLOT_W     = $clog2(robDepth);
   localparam int CW         = lenWidth + 1;
   localparam int BW         = addressWidth - SHIFT;
   localparam int CMPW       = (BW > CW) ? BW : CW;

   state_t                  r_state;
   logic [addressWidth-1:0] r_base;
   logic [lenWidth-1:0]     r_len;
   logic [CW-1:0]           r_issued;
   logic [CW-1:0]           r_retired;
   logic                    r_req_valid;
   logic [addressWidth-1:0] r_req_addr;
   logic                    r_err;

   logic                    w_req_fire;
   logic                    w_out_fire;
   logic [CW-1:0]           w_issued_nxt;
   logic [CW-1:0]           w_retired_nxt;
   logic [CW-1:0]           w_occ_nxt;
   logic [CW-1:0]           w_len_ext;
   logic                    w_more;
   logic                    w_room;
   logic [addressWidth-1:0] w_next_addr;
   logic [addressWidth-1:0] w_resp_beat;
   logic [CMPW-1:0]         w_beat_ext;
   logic                    w_outstanding;
   logic [SLOT_W-1:0]       w_slot;
   logic [SLOT_W-1:0]       w_head_slot;
   logic [robDepth-1:0]     w_rob_valid;
   logic                    w_head_valid;
   logic [dataWidth-1:0]    w_head_data;
   logic                    w_accept;

   assign w_req_fire    = r_req_valid && dram_req_ready;
   assign w_out_fire    = w_head_valid && out_ready;
   assign w_issued_nxt  = r_issued + CW'(w_req_fire);
   assign w_retired_nxt = r_retired + CW'(w_out_fire);
   assign w_occ_nxt     = w_issued_nxt - w_retired_nxt;
   assign w_len_ext     = {1'b0, r_len};
   assign w_more        = (w_issued_nxt != w_len_ext);
   assign w_room        = (w_occ_nxt < CW'(robDepth));
   assign w_next_addr   = r_base + addressWidth'(w_issued_nxt) * addressWidth'(BEAT_BYTES);

   // Beat index is taken modulo the address space so wrapped bursts still map.
   assign w_resp_beat   = (dram_resp_payload_addr - r_base) >> SHIFT;
   assign w_beat_ext    = CMPW'(w_resp_beat);
   assign w_outstanding = (w_beat_ext >= CMPW'(r_retired)) && (w_beat_ext < CMPW'(r_issued));
   assign w_slot        = w_resp_beat[SLOT_W-1:0];
   assign w_head_slot   = r_retired[SLOT_W-1:0];
   assign w_accept      = dram_resp_valid && !dram_resp_payload_is_write &&
                          (r_state != IDLE) && w_outstanding && !w_rob_valid[w_slot];

   dram_burst_rob #(
      .dataWidth (dataWidth),
      .robDepth  (robDepth)
   ) u_rob (
      .clk          (clk),
      .rst          (rst),
      .i_wr_en      (w_accept),
      .i_wr_slot    (w_slot),
      .i_wr_data    (dram_resp_payload_data),
      .i_clr_en     (w_out_fire),
      .i_clr_slot   (w_head_slot),
      .i_head_slot  (w_head_slot),
      .o_head_valid (w_head_valid),
      .o_head_data  (w_head_data),
      .o_valid      (w_rob_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_base      <= '0;
         r_len       <= '0;
         r_issued    <= '0;
         r_retired   <= '0;
         r_req_valid <= 1'b0;
         r_req_addr  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_err <= dram_resp_valid && !w_accept;
         case (r_state)
            IDLE: begin
               if (cmd_valid && (cmd_payload_len != '0)) begin
                  r_base      <= cmd_payload_addr;
                  r_len       <= cmd_payload_len;
                  r_issued    <= '0;
                  r_retired   <= '0;
                  r_req_valid <= 1'b1;
                  r_req_addr  <= cmd_payload_addr;
                  r_state     <= ISSUE;
               end
            end
            ISSUE: begin
               r_issued  <= w_issued_nxt;
               r_retired <= w_retired_nxt;
               if (w_req_fire && !w_more) begin
                  r_req_valid <= 1'b0;
                  r_state     <= DRAIN;
               end else if (!(r_req_valid && !dram_req_ready)) begin
                  // Request is only re-evaluated when not held by backpressure.
                  r_req_valid <= w_room;
                  r_req_addr  <= w_next_addr;
               end
            end
            DRAIN: begin
               r_retired <= w_retired_nxt;
               if (w_out_fire && out_payload_last) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_req_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef DRAM_BURST_READER_STATS_EN
   logic [31:0] r_stat_beats;
   logic [31:0] r_stat_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_beats <= '0;
         r_stat_stall <= '0;
      end else begin
         if (w_out_fire && (r_stat_beats != '1)) begin
            r_stat_beats <= r_stat_beats + 32'd1;
         end
         if (r_req_valid && !dram_req_ready && (r_stat_stall != '1)) begin
            r_stat_stall <= r_stat_stall + 32'd1;
         end
      end
   end

   assign stat_beats        = r_stat_beats;
   assign stat_stall_cycles = r_stat_stall;
`endif

   assign cmd_ready                 = (r_state == IDLE);
   assign busy                      = (r_state != IDLE);
   assign dram_req_valid            = r_req_valid;
   assign dram_req_payload_addr     = r_req_addr;
   assign dram_req_payload_data     = '0;
   assign dram_req_payload_is_write = 1'b0;
   assign dram_resp_ready           = 1'b1;
   assign out_valid                 = w_head_valid;
   assign out_payload_data          = w_head_data;
   assign out_payload_last          = (r_retired == (w_len_ext - CW'(1)));
   assign err_unexpected            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dram_burst_reader
// Brief    : Self-checking bench for dram_burst_reader with a scripted DRAM
//            responder and an expected-beat scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_dram_burst_reader;

   localparam int AW = 32;
   localparam int DW = 256;
   localparam int LW = 16;
   localparam int RD = 16;
   localparam int M_AUTO = 0;
   localparam int M_HOLD = 1;
   localparam int M_PERM = 2;

   typedef struct {
      logic [31:0] base;
      int          len;
      int          mode;
      logic [31:0] exp_req1;
   } vec_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [31:0] addr;
      logic        is_write;
   } inj_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_payload_addr = '0;
   logic [LW-1:0] cmd_payload_len = '0;
   logic          dram_req_valid;
   logic          dram_req_ready = 1'b1;
   logic [AW-1:0] dram_req_payload_addr;
   logic [DW-1:0] dram_req_payload_data;
   logic          dram_req_payload_is_write;
   logic          dram_resp_valid = 1'b0;
   logic          dram_resp_ready;
   logic [AW-1:0] dram_resp_payload_addr = '0;
   logic [DW-1:0] dram_resp_payload_data = '0;
   logic          dram_resp_payload_is_write = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_payload_data;
   logic          out_payload_last;
   logic          busy;
   logic          err_unexpected;
`ifdef DRAM_BURST_READER_STATS_EN
   logic [31:0]   stat_beats;
   logic [31:0]   stat_stall_cycles;
`endif

   always #5 clk = ~clk;

   dram_burst_reader #(
      .addressWidth (AW),
      .dataWidth    (DW),
      .lenWidth     (LW),
      .robDepth     (RD)
   ) dut (
      .clk                        (clk),
      .rst                        (rst),
      .cmd_valid                  (cmd_valid),
      .cmd_ready                  (cmd_ready),
      .cmd_payload_addr           (cmd_payload_addr),
      .cmd_payload_len            (cmd_payload_len),
      .dram_req_valid             (dram_req_valid),
      .dram_req_ready             (dram_req_ready),
      .dram_req_payload_addr      (dram_req_payload_addr),
      .dram_req_payload_data      (dram_req_payload_data),
      .dram_req_payload_is_write  (dram_req_payload_is_write),
      .dram_resp_valid            (dram_resp_valid),
      .dram_resp_ready            (dram_resp_ready),
      .dram_resp_payload_addr     (dram_resp_payload_addr),
      .dram_resp_payload_data     (dram_resp_payload_data),
      .dram_resp_payload_is_write (dram_resp_payload_is_write),
      .out_valid                  (out_valid),
      .out_ready                  (out_ready),
      .out_payload_data           (out_payload_data),
      .out_payload_last           (out_payload_last),
      .busy                       (busy),
      .err_unexpected             (err_unexpected)
`ifdef DRAM_BURST_READER_STATS_EN
      ,
      .stat_beats                 (stat_beats),
      .stat_stall_cycles          (stat_stall_cycles)
`endif
   );

   function automatic logic [DW-1:0] dat(input logic [31:0] a);
      return {a, ~a, a ^ 32'h1234_5678, a + 32'd7, a ^ 32'hDEAD_BEEF,
              {a[15:0], a[31:16]}, ~(a + 32'd3), a ^ 32'h0F0F_F0F0};
   endfunction

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      chk(nm, {{(DW-1){1'b0}}, act}, {{(DW-1){1'b0}}, exp});
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      chk(nm, {{(DW-32){1'b0}}, act}, {{(DW-32){1'b0}}, exp});
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      chk32(nm, 32'(act), 32'(exp));
   endtask

   // Handshake monitor: sampled at the clock edge where the transfer happens.
   logic [31:0]   req_hist [256];
   int            req_n = 0;
   logic [DW-1:0] obs_d [256];
   logic          obs_l [256];
   int            obs_n = 0;
   int            err_cnt = 0;
   logic          bad_req = 1'b0;

   always @(posedge clk) begin
      if (dram_req_valid && dram_req_ready && (req_n < 256)) begin
         req_hist[req_n] <= dram_req_payload_addr;
         req_n           <= req_n + 1;
         if ((dram_req_payload_data != '0) || dram_req_payload_is_write) bad_req <= 1'b1;
      end
      if (out_valid && out_ready && (obs_n < 256)) begin
         obs_d[obs_n] <= out_payload_data;
         obs_l[obs_n] <= out_payload_last;
         obs_n        <= obs_n + 1;
      end
      if (err_unexpected) err_cnt <= err_cnt + 1;
   end

   // DRAM responder; all control comes from variables owned by the test.
   int   mode = M_AUTO;
   int   rel_req = 0;
   inj_t inj [16];
   int   inj_wr = 0;

   initial begin
      int rd_idx;
      int rel_done;
      int inj_rd;
      int perm_k;
      int perm [4];
      rd_idx = 0; rel_done = 0; inj_rd = 0; perm_k = 0;
      perm = '{3, 1, 0, 2};
      forever begin
         @(posedge clk);
         #1;
         dram_resp_valid            = 1'b0;
         dram_resp_payload_is_write = 1'b0;
         if (inj_rd < inj_wr) begin
            dram_resp_valid            = 1'b1;
            dram_resp_payload_addr     = inj[inj_rd].addr;
            dram_resp_payload_is_write = inj[inj_rd].is_write;
            dram_resp_payload_data     = '1;
            inj_rd++;
         end else if ((mode == M_AUTO && rd_idx < req_n) ||
                      (mode == M_HOLD && rel_done < rel_req && rd_idx < req_n)) begin
            dram_resp_valid        = 1'b1;
            dram_resp_payload_addr = req_hist[rd_idx];
            dram_resp_payload_data = dat(req_hist[rd_idx]);
            if (mode == M_HOLD) rel_done++;
            rd_idx++;
         end else if (mode == M_PERM && (perm_k != 0 || req_n - rd_idx >= 4)) begin
            dram_resp_valid        = 1'b1;
            dram_resp_payload_addr = req_hist[rd_idx + perm[perm_k]];
            dram_resp_payload_data = dat(req_hist[rd_idx + perm[perm_k]]);
            perm_k++;
            if (perm_k == 4) begin
               perm_k = 0;
               rd_idx += 4;
            end
         end
      end
   end

   beat_t exp_q [$];
   int    obs_rd = 0;

   task automatic at_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_obs(output bit saw_last);
      beat_t e;
      saw_last = 1'b0;
      while (obs_rd < obs_n) begin
         if (exp_q.size() == 0) begin
            chki("unexpected_beat", exp_q.size(), 1);
         end else begin
            e = exp_q.pop_front();
            chk("beat_data", obs_d[obs_rd], e.data);
            chkb("beat_last", obs_l[obs_rd], e.last);
            if (obs_l[obs_rd]) saw_last = 1'b1;
         end
         obs_rd++;
      end
   endtask

   task automatic wait_cycles(input int n);
      bit d;
      repeat (n) @(negedge clk);
      drain_obs(d);
   endtask

   task automatic send_cmd(input logic [31:0] base, input int len, input bit expect_beats);
      at_edge();
      chkb("cmd_ready_idle", cmd_ready, 1'b1);
      cmd_valid        = 1'b1;
      cmd_payload_addr = base;
      cmd_payload_len  = LW'(len);
      if (expect_beats) begin
         for (int i = 0; i < len; i++) begin
            exp_q.push_back('{dat(base + 32'(i) * 32'd32), (i == len - 1)});
         end
      end
      at_edge();
      cmd_valid       = 1'b0;
      cmd_payload_len = '0;
   endtask

   task automatic wait_idle(input string nm);
      bit d;
      for (int c = 0; c < 400 && busy; c++) begin
         @(negedge clk);
         drain_obs(d);
      end
      chkb(nm, busy, 1'b0);
   endtask

   task automatic run_burst(input logic [31:0] base, input int len, input int m, input logic [31:0] exp1);
      int s;
      bit done;
      bit prev_hit;
      s = req_n;
      mode = m;
      done = 1'b0;
      prev_hit = 1'b0;
      send_cmd(base, len, 1'b1);
      chkb("first_req_valid", dram_req_valid, 1'b1);
      chk32("first_req_addr", dram_req_payload_addr, base);
      for (int c = 0; c < 400 && !done; c++) begin
         @(negedge clk);
         if (prev_hit) chkb("ooo_valid_after_head", out_valid, 1'b1);
         prev_hit = (m == M_PERM) && dram_resp_valid && (dram_resp_payload_addr == base);
         if (prev_hit) chkb("ooo_valid_before_head", out_valid, 1'b0);
         drain_obs(done);
         if (done) chkb("busy_after_last", busy, 1'b0);
      end
      chkb("burst_done", done, 1'b1);
      chki("req_count", req_n - s, len);
      if (len > 1) chk32("second_req_addr", req_hist[s + 1], exp1);
      chki("exp_empty", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [4];
      int   s;
      int   e0;
      int   o0;
      vecs[0] = '{32'h0000_1000, 4, M_AUTO, 32'h0000_1020};
      vecs[1] = '{32'h0000_1000, 4, M_PERM, 32'h0000_1020};
      vecs[2] = '{32'hFFFF_FFE0, 2, M_AUTO, 32'h0000_0000};
      vecs[3] = '{32'h0000_0040, 3, M_AUTO, 32'h0000_0060};

      rst = 1'b1;
      repeat (3) @(negedge clk);
      chkb("rst_cmd_ready", cmd_ready, 1'b1);
      chkb("rst_req_valid", dram_req_valid, 1'b0);
      chkb("rst_out_valid", out_valid, 1'b0);
      chkb("rst_busy", busy, 1'b0);
      chkb("rst_err", err_unexpected, 1'b0);
      chkb("rst_resp_ready", dram_resp_ready, 1'b1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         run_burst(vecs[i].base, vecs[i].len, vecs[i].mode, vecs[i].exp_req1);
      end

      // Zero-length command is consumed without starting a burst.
      s = req_n;
      send_cmd(32'h0000_2000, 0, 1'b0);
      chkb("len0_busy", busy, 1'b0);
      chkb("len0_req_valid", dram_req_valid, 1'b0);
      wait_cycles(3);
      chki("len0_no_req", req_n - s, 0);

      // Outstanding limit, request backpressure and output stall.
      mode = M_HOLD;
      dram_req_ready = 1'b0;
      s = req_n;
      send_cmd(32'h0000_8000, 40, 1'b1);
      wait_cycles(3);
      chkb("stall_req_valid", dram_req_valid, 1'b1);
      chk32("stall_req_addr", dram_req_payload_addr, 32'h0000_8000);
      at_edge();
      dram_req_ready = 1'b1;
      wait_cycles(30);
      chki("rob_full_count", req_n - s, RD);
      chkb("rob_full_valid", dram_req_valid, 1'b0);
      at_edge();
      out_ready = 1'b0;
      rel_req++;
      wait_cycles(3);
      chkb("hold_out_valid", out_valid, 1'b1);
      chk("hold_out_data", out_payload_data, dat(32'h0000_8000));
      chkb("hold_out_last", out_payload_last, 1'b0);
      wait_cycles(2);
      chk("hold_data_stable", out_payload_data, dat(32'h0000_8000));
      chki("hold_no_extra_req", req_n - s, RD);
      at_edge();
      out_ready = 1'b1;
      wait_cycles(5);
      chki("one_more_req", req_n - s, RD + 1);
      chkb("one_more_valid", dram_req_valid, 1'b0);
      mode = M_AUTO;
      wait_idle("long_burst_done");
      chki("long_req_count", req_n - s, 40);
      chki("long_exp_empty", exp_q.size(), 0);

      // Dropped responses: idle, write-ack, duplicate (valid), duplicate (retired).
      e0 = err_cnt;
      at_edge();
      inj[inj_wr] = '{32'h0000_1000, 1'b0};
      inj_wr++;
      wait_cycles(4);
      chki("err_idle", err_cnt - e0, 1);
      mode = M_HOLD;
      send_cmd(32'h0000_3000, 2, 1'b1);
      wait_cycles(4);
      at_edge();
      inj[inj_wr] = '{32'h0000_3000, 1'b1};
      inj_wr++;
      wait_cycles(4);
      chki("err_write_ack", err_cnt - e0, 2);
      chkb("write_ack_not_stored", out_valid, 1'b0);
      at_edge();
      out_ready = 1'b0;
      rel_req++;
      wait_cycles(4);
      chkb("dup_head_valid", out_valid, 1'b1);
      at_edge();
      inj[inj_wr] = '{32'h0000_3000, 1'b0};
      inj_wr++;
      wait_cycles(4);
      chki("err_dup_valid", err_cnt - e0, 3);
      chk("dup_data_kept", out_payload_data, dat(32'h0000_3000));
      at_edge();
      out_ready = 1'b1;
      wait_cycles(4);
      at_edge();
      inj[inj_wr] = '{32'h0000_3000, 1'b0};
      inj_wr++;
      wait_cycles(4);
      chki("err_dup_retired", err_cnt - e0, 4);
      at_edge();
      rel_req++;
      wait_idle("err_burst_done");
      chki("err_exp_empty", exp_q.size(), 0);
      chki("err_total", err_cnt - e0, 4);

      // Asynchronous reset with three reads outstanding.
      s = req_n;
      send_cmd(32'h0000_5000, 8, 1'b0);
      for (int c = 0; c < 50 && (req_n - s) < 3; c++) @(negedge clk);
      chki("pre_rst_outstanding", req_n - s, 3);
      chkb("pre_rst_req_valid", dram_req_valid, 1'b1);
      rst = 1'b1;
      #1;
      chkb("async_rst_req_valid", dram_req_valid, 1'b0);
      chkb("async_rst_busy", busy, 1'b0);
      chkb("async_rst_cmd_ready", cmd_ready, 1'b1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      e0 = err_cnt;
      o0 = obs_n;
      mode = M_AUTO;
      wait_cycles(8);
      chki("late_resp_err", err_cnt - e0, 3);
      chki("late_resp_no_output", obs_n - o0, 0);
      run_burst(32'h0000_6000, 1, M_AUTO, 32'h0);

      chkb("req_fields_zero", bad_req, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
